// File: rtl/countdown_timer.sv
// Multi-digit BCD round timer: loads a start time, counts down one unit per
// prescaled tick, supports pause/abort, and pulses time_up on reaching zero.
module countdown_timer #(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 100000000,
    parameter int TICK_W   = 27
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gaming,
    input  logic                  start,
    input  logic                  pause,
    input  logic [4*DIGITS-1:0]   init_bcd,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  running,
    output logic                  time_up
);

    localparam int W = 4 * DIGITS;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t            state;
    logic [TICK_W-1:0] cnt;
    logic [W-1:0]      init_clamped;
    logic [W-1:0]      dec_next;

    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        return r;
    endfunction

    // Ripple borrow from digit 0 upward; a zero digit wraps to 9 and passes the borrow on.
    function automatic logic [W-1:0] dec_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign init_clamped = clamp_bcd(init_bcd);
    assign dec_next     = dec_bcd(digits);

    // NOTE: all state lives in one clocked block with non-blocking assignments so every
    // register samples the pre-edge values; reset is synchronous, so it sits inside the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            digits  <= '0;
            cnt     <= '0;
            running <= 1'b0;
            time_up <= 1'b0;
        end else begin
            time_up <= 1'b0;
            if (!gaming) begin
                state   <= IDLE;
                cnt     <= '0;
                running <= 1'b0;
            end else if (start) begin
                digits <= init_clamped;
                cnt    <= '0;
                if (init_clamped == '0) begin
                    state   <= DONE;
                    time_up <= 1'b1;
                    running <= 1'b0;
                end else begin
                    state   <= RUN;
                    running <= 1'b1;
                end
            end else begin
                case (state)
                    // Releasing pause counts on the same edge, continuing the held prescaler phase.
                    RUN, PAUSE: begin
                        if (pause) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else begin
                            state   <= RUN;
                            running <= 1'b1;
                            if (cnt == TICK_LAST) begin
                                cnt    <= '0;
                                digits <= dec_next;
                                if (dec_next == '0) begin
                                    state   <= DONE;
                                    time_up <= 1'b1;
                                    running <= 1'b0;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with DIGITS=2, TICK_DIV=4.
module tb_countdown_timer;

    logic       clk;
    logic       rst;
    logic       gaming;
    logic       start;
    logic       pause;
    logic [7:0] init_bcd;
    logic [7:0] digits;
    logic       running;
    logic       time_up;

    int tests_run = 0;
    int tests_failed = 0;

    countdown_timer #(
        .DIGITS  (2),
        .TICK_DIV(4),
        .TICK_W  (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .gaming  (gaming),
        .start   (start),
        .pause   (pause),
        .init_bcd(init_bcd),
        .digits  (digits),
        .running (running),
        .time_up (time_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit before driving/sampling.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst      = 1'b1;
        gaming   = 1'b0;
        start    = 1'b0;
        pause    = 1'b0;
        init_bcd = 8'h00;

        // Reset
        tick(2);
        rst = 1'b0;
        check("reset_digits", 32'(digits), 32'h00);
        check("reset_running", 32'(running), 32'h0);
        check("reset_time_up", 32'(time_up), 32'h0);

        // Full countdown from 12
        gaming   = 1'b1;
        start    = 1'b1;
        init_bcd = 8'h12;
        tick(1);
        start = 1'b0;
        check("load12_digits", 32'(digits), 32'h12);
        check("load12_running", 32'(running), 32'h1);
        tick(3);
        check("pre_tick_hold", 32'(digits), 32'h12);
        tick(1);
        check("first_dec", 32'(digits), 32'h11);
        tick(4);
        check("second_dec", 32'(digits), 32'h10);
        tick(4);
        check("borrow_09", 32'(digits), 32'h09);
        tick(35);
        check("at_01", 32'(digits), 32'h01);
        check("no_early_time_up", 32'(time_up), 32'h0);
        tick(1);
        check("reach_00", 32'(digits), 32'h00);
        check("time_up_pulse", 32'(time_up), 32'h1);
        check("done_not_running", 32'(running), 32'h0);
        tick(1);
        check("time_up_one_cycle", 32'(time_up), 32'h0);
        tick(4);
        check("done_holds_00", 32'(digits), 32'h00);

        // Pause keeps count and prescaler phase
        start    = 1'b1;
        init_bcd = 8'h03;
        tick(1);
        start = 1'b0;
        tick(2);
        pause = 1'b1;
        tick(1);
        check("paused_running", 32'(running), 32'h0);
        tick(9);
        check("paused_frozen", 32'(digits), 32'h03);
        pause = 1'b0;
        tick(1);
        check("resume_running", 32'(running), 32'h1);
        check("resume_no_dec_yet", 32'(digits), 32'h03);
        tick(1);
        check("resume_dec", 32'(digits), 32'h02);

        // Zero load and clamping
        start    = 1'b1;
        init_bcd = 8'h00;
        tick(1);
        start = 1'b0;
        check("zero_load_time_up", 32'(time_up), 32'h1);
        check("zero_load_running", 32'(running), 32'h0);
        tick(1);
        check("zero_load_pulse_end", 32'(time_up), 32'h0);
        start    = 1'b1;
        init_bcd = 8'h1F;
        tick(1);
        start = 1'b0;
        check("clamp_1F", 32'(digits), 32'h19);
        check("clamp_running", 32'(running), 32'h1);

        // Abort mid-count at 07
        tick(48);
        check("reach_07", 32'(digits), 32'h07);
        gaming = 1'b0;
        tick(1);
        check("abort_running", 32'(running), 32'h0);
        tick(8);
        check("abort_holds", 32'(digits), 32'h07);
        start    = 1'b1;
        init_bcd = 8'h55;
        tick(1);
        start = 1'b0;
        check("start_ignored_digits", 32'(digits), 32'h07);
        check("start_ignored_running", 32'(running), 32'h0);

        // Reset beats start mid-run
        gaming   = 1'b1;
        start    = 1'b1;
        init_bcd = 8'h45;
        tick(1);
        start = 1'b0;
        check("load45", 32'(digits), 32'h45);
        tick(2);
        rst   = 1'b1;
        start = 1'b1;
        tick(1);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_wins_digits", 32'(digits), 32'h00);
        check("rst_wins_running", 32'(running), 32'h0);
        tick(5);
        check("idle_after_rst", 32'(digits), 32'h00);
        check("idle_not_running", 32'(running), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
